// File: rtl/vesa_cfg_if.sv
// vesa_cfg_if: host configuration bus and commit request for vesa_mode_ctrl
interface vesa_cfg_if;
    logic        cfg_we;
    logic        cfg_re;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        commit;
    modport master (output cfg_we, cfg_re, cfg_addr, cfg_wdata, commit, input cfg_rdata);
    modport slave (input cfg_we, cfg_re, cfg_addr, cfg_wdata, commit, output cfg_rdata);
endinterface

// File: rtl/vesa_mode_ctrl.sv
// vesa_mode_ctrl: run-time VESA timing mode controller; shadow set is validated on commit,
// staged, and applied to the timing core only at a frame boundary with blanking.
module vesa_mode_ctrl #(
    parameter int DEF_H_ACTIVE   = 3840,
    parameter int DEF_H_FP       = 136,
    parameter int DEF_H_SYNC     = 24,
    parameter int DEF_H_BP       = 128,
    parameter int DEF_V_ACTIVE   = 2160,
    parameter int DEF_V_FP       = 3,
    parameter int DEF_V_SYNC     = 4,
    parameter int DEF_V_BP       = 32,
    parameter int SETTLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 16777215
) (
    input  logic        clk,
    input  logic        rst_n,
    vesa_cfg_if.slave   cfg,
    input  logic        frame_end,
    output logic        tg_enable,
    output logic        tg_load,
    output logic [12:0] tg_h_active,
    output logic [12:0] tg_h_fp,
    output logic [12:0] tg_h_sync,
    output logic [12:0] tg_h_bp,
    output logic [11:0] tg_v_active,
    output logic [11:0] tg_v_fp,
    output logic [11:0] tg_v_sync,
    output logic [11:0] tg_v_bp,
    output logic        tg_hpol,
    output logic        tg_vpol,
    output logic        blank,
    output logic        busy,
    output logic        locked,
    output logic        cfg_err
);
    typedef enum logic [2:0] {OFF = 3'd0, RUN = 3'd1, PEND = 3'd2, LOAD = 3'd3, SETTLE = 3'd4} state_t;
    localparam logic [12:0] DEF_H [4] = '{13'(DEF_H_ACTIVE), 13'(DEF_H_FP), 13'(DEF_H_SYNC), 13'(DEF_H_BP)};
    localparam logic [11:0] DEF_V [4] = '{12'(DEF_V_ACTIVE), 12'(DEF_V_FP), 12'(DEF_V_SYNC), 12'(DEF_V_BP)};
    state_t      state;
    logic [12:0] sh_h [4];
    logic [12:0] stg_h [4];
    logic [12:0] ap_h [4];
    logic [12:0] src_h [4];
    logic [11:0] sh_v [4];
    logic [11:0] stg_v [4];
    logic [11:0] ap_v [4];
    logic [11:0] src_v [4];
    logic [2:0]  ctrl, stg_ctrl, src_ctrl;
    logic        commit_drop;
    logic [3:0]  scnt;
    logic [23:0] wcnt;
    logic [13:0] h_sum;
    logic [12:0] v_sum;
    logic        valid, accept, timeout, load_go, unused;
    logic [15:0] rd;
    assign tg_h_active = ap_h[0];
    assign tg_h_fp     = ap_h[1];
    assign tg_h_sync   = ap_h[2];
    assign tg_h_bp     = ap_h[3];
    assign tg_v_active = ap_v[0];
    assign tg_v_fp     = ap_v[1];
    assign tg_v_sync   = ap_v[2];
    assign tg_v_bp     = ap_v[3];
    assign unused      = ^cfg.cfg_wdata[15:13];
    always_comb begin
        h_sum = 14'(sh_h[0]) + 14'(sh_h[1]) + 14'(sh_h[2]) + 14'(sh_h[3]);
        v_sum = 13'(sh_v[0]) + 13'(sh_v[1]) + 13'(sh_v[2]) + 13'(sh_v[3]);
        valid = (|sh_h[0]) && (|sh_h[2]) && (|sh_v[0]) && (|sh_v[2]) && !h_sum[13] && !v_sum[12];
        accept = cfg.commit && !busy && valid;
        timeout = wcnt == 24'(TIMEOUT_CYCLES - 1);
        load_go = (state == OFF && accept) || (state == PEND && (frame_end || timeout));
        // from OFF the load happens in the commit cycle, before the staged copy exists
        for (int i = 0; i < 4; i++) begin
            src_h[i] = state == OFF ? sh_h[i] : stg_h[i];
            src_v[i] = state == OFF ? sh_v[i] : stg_v[i];
        end
        src_ctrl = state == OFF ? ctrl : stg_ctrl;
        rd = cfg.cfg_addr < 4'd4 ? {3'd0, sh_h[cfg.cfg_addr[1:0]]} :
             cfg.cfg_addr < 4'd8 ? {4'd0, sh_v[cfg.cfg_addr[1:0]]} :
             cfg.cfg_addr == 4'd8 ? {13'd0, ctrl} :
             cfg.cfg_addr == 4'd9 ? {9'd0, state, commit_drop, cfg_err, locked, busy} : 16'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            sh_h <= DEF_H;
            stg_h <= DEF_H;
            ap_h <= DEF_H;
            sh_v <= DEF_V;
            stg_v <= DEF_V;
            ap_v <= DEF_V;
            ctrl <= '0;
            stg_ctrl <= '0;
            tg_hpol <= 1'b0;
            tg_vpol <= 1'b0;
            tg_enable <= 1'b0;
            tg_load <= 1'b0;
            blank <= 1'b1;
            busy <= 1'b0;
            locked <= 1'b0;
            cfg_err <= 1'b0;
            commit_drop <= 1'b0;
            scnt <= '0;
            wcnt <= '0;
            cfg.cfg_rdata <= '0;
        end else begin
            tg_load <= 1'b0;
            if (cfg.cfg_re) cfg.cfg_rdata <= rd;
            if (cfg.cfg_we) begin
                if (cfg.cfg_addr < 4'd4) sh_h[cfg.cfg_addr[1:0]] <= cfg.cfg_wdata[12:0];
                else if (cfg.cfg_addr < 4'd8) sh_v[cfg.cfg_addr[1:0]] <= cfg.cfg_wdata[11:0];
                else if (cfg.cfg_addr == 4'd8) ctrl <= cfg.cfg_wdata[2:0];
                else if (cfg.cfg_addr == 4'd9) begin
                    cfg_err <= 1'b0;
                    commit_drop <= 1'b0;
                end
            end
            // new error events win over a same-cycle STATUS clear
            if (cfg.commit && busy) commit_drop <= 1'b1;
            if ((cfg.commit && !busy && !valid) || (state == PEND && timeout && !frame_end)) cfg_err <= 1'b1;
            if (accept) begin
                stg_h <= sh_h;
                stg_v <= sh_v;
                stg_ctrl <= ctrl;
            end
            if (load_go) begin
                state <= LOAD;
                ap_h <= src_h;
                ap_v <= src_v;
                tg_hpol <= src_ctrl[0];
                tg_vpol <= src_ctrl[1];
                tg_load <= src_ctrl[2];
                tg_enable <= src_ctrl[2];
                blank <= 1'b1;
                locked <= 1'b0;
                busy <= 1'b1;
                scnt <= '0;
            end else begin
                case (state)
                    RUN: if (accept) begin
                        state <= PEND;
                        busy <= 1'b1;
                        wcnt <= '0;
                    end
                    PEND: wcnt <= wcnt + 24'd1;
                    LOAD: if (tg_enable) state <= SETTLE;
                    else begin
                        state <= OFF;
                        busy <= 1'b0;
                    end
                    SETTLE: if (frame_end) begin
                        if (scnt == 4'(SETTLE_FRAMES - 1)) begin
                            state <= RUN;
                            locked <= 1'b1;
                            blank <= 1'b0;
                            busy <= 1'b0;
                        end else scnt <= scnt + 4'd1;
                    end
                    OFF: ;
                    default: state <= OFF;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vesa_mode_ctrl.sv
// tb_vesa_mode_ctrl: directed vectors with hand-computed expectations for vesa_mode_ctrl
module tb_vesa_mode_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, frame_end = 1'b0;
    logic        tg_enable, tg_load, tg_hpol, tg_vpol, blank, busy, locked, cfg_err;
    logic [12:0] tg_h_active, tg_h_fp, tg_h_sync, tg_h_bp;
    logic [11:0] tg_v_active, tg_v_fp, tg_v_sync, tg_v_bp;
    logic [15:0] rdat;
    int          checks = 0, errors = 0;
    vesa_cfg_if cfg();
    vesa_mode_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg), .frame_end(frame_end),
        .tg_enable(tg_enable), .tg_load(tg_load),
        .tg_h_active(tg_h_active), .tg_h_fp(tg_h_fp), .tg_h_sync(tg_h_sync), .tg_h_bp(tg_h_bp),
        .tg_v_active(tg_v_active), .tg_v_fp(tg_v_fp), .tg_v_sync(tg_v_sync), .tg_v_bp(tg_v_bp),
        .tg_hpol(tg_hpol), .tg_vpol(tg_vpol),
        .blank(blank), .busy(busy), .locked(locked), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cfg.cfg_we = 1'b1;
        cfg.cfg_addr = a;
        cfg.cfg_wdata = d;
        tick();
        cfg.cfg_we = 1'b0;
    endtask
    task automatic rd(input logic [3:0] a);
        cfg.cfg_re = 1'b1;
        cfg.cfg_addr = a;
        tick();
        cfg.cfg_re = 1'b0;
        rdat = cfg.cfg_rdata;
    endtask
    task automatic do_commit();
        cfg.commit = 1'b1;
        tick();
        cfg.commit = 1'b0;
    endtask
    task automatic fe_pulse();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask
    initial begin
        cfg.cfg_we = 1'b0;
        cfg.cfg_re = 1'b0;
        cfg.commit = 1'b0;
        cfg.cfg_addr = '0;
        cfg.cfg_wdata = '0;
        repeat (2) tick();
        chk("rst_enable", tg_enable, 0);
        chk("rst_load", tg_load, 0);
        chk("rst_blank", blank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_rdata", cfg.cfg_rdata, 0);
        chk("rst_h_active", tg_h_active, 3840);
        chk("rst_v_bp", tg_v_bp, 32);
        rst_n = 1'b1;
        // first bring-up from OFF: no frame wait
        wr(8, 16'h4);
        do_commit();
        chk("off_load_pulse", tg_load, 1);
        chk("off_load_enable", tg_enable, 1);
        chk("off_load_blank", blank, 1);
        chk("off_load_busy", busy, 1);
        chk("off_h_active", tg_h_active, 3840);
        chk("off_v_active", tg_v_active, 2160);
        chk("off_h_fp", tg_h_fp, 136);
        chk("off_v_sync", tg_v_sync, 4);
        tick();
        chk("settle_load_low", tg_load, 0);
        chk("settle_locked", locked, 0);
        fe_pulse();
        chk("settle_fe1_locked", locked, 0);
        fe_pulse();
        chk("run_locked", locked, 1);
        chk("run_blank", blank, 0);
        chk("run_busy", busy, 0);
        rd(9);
        chk("run_status", rdat, 16'h12);
        // mode change while running waits for the frame boundary
        wr(0, 1920); wr(1, 88); wr(2, 44); wr(3, 148);
        wr(4, 1080); wr(5, 4); wr(6, 5); wr(7, 36);
        rd(0);
        chk("rd_h_active", rdat, 1920);
        rd(8);
        chk("rd_ctrl", rdat, 4);
        do_commit();
        chk("pend_busy", busy, 1);
        chk("pend_blank", blank, 0);
        chk("pend_locked", locked, 1);
        repeat (3) tick();
        chk("pend_h_hold", tg_h_active, 3840);
        chk("pend_v_hold", tg_v_active, 2160);
        fe_pulse();
        chk("pend_load_pulse", tg_load, 1);
        chk("pend_load_blank", blank, 1);
        chk("pend_load_locked", locked, 0);
        chk("new_h_active", tg_h_active, 1920);
        chk("new_h_fp", tg_h_fp, 88);
        chk("new_h_sync", tg_h_sync, 44);
        chk("new_h_bp", tg_h_bp, 148);
        chk("new_v_active", tg_v_active, 1080);
        chk("new_v_fp", tg_v_fp, 4);
        chk("new_v_sync", tg_v_sync, 5);
        chk("new_v_bp", tg_v_bp, 36);
        tick();
        fe_pulse();
        chk("relock_fe1", locked, 0);
        fe_pulse();
        chk("relock_fe2", locked, 1);
        // invalid sets: zero sync, then H total overflow
        wr(2, 0);
        do_commit();
        chk("zsync_err", cfg_err, 1);
        chk("zsync_busy", busy, 0);
        chk("zsync_locked", locked, 1);
        chk("zsync_h_sync", tg_h_sync, 44);
        rd(9);
        chk("zsync_status", rdat, 16'h16);
        wr(9, 0);
        chk("err_clear1", cfg_err, 0);
        wr(2, 44); wr(0, 8000); wr(1, 200);
        do_commit();
        chk("hsum_err", cfg_err, 1);
        chk("hsum_busy", busy, 0);
        chk("hsum_h_active", tg_h_active, 1920);
        wr(9, 0);
        chk("err_clear2", cfg_err, 0);
        // H total exactly 8191 is accepted
        wr(1, 100); wr(3, 47);
        do_commit();
        chk("h8191_err", cfg_err, 0);
        chk("h8191_busy", busy, 1);
        fe_pulse();
        chk("h8191_load", tg_load, 1);
        chk("h8191_h_active", tg_h_active, 8000);
        tick();
        do_commit();
        chk("drop_busy", busy, 1);
        chk("drop_h_active", tg_h_active, 8000);
        rd(9);
        chk("drop_status", rdat, 16'h49);
        fe_pulse();
        chk("drop_fe1", locked, 0);
        fe_pulse();
        chk("drop_fe2", locked, 1);
        wr(9, 0);
        // no frame_end: forced load after timeout
        do_commit();
        chk("to_pend_busy", busy, 1);
        repeat (99) tick();
        chk("to_c99_load", tg_load, 0);
        chk("to_c99_err", cfg_err, 0);
        tick();
        chk("to_c100_load", tg_load, 1);
        chk("to_c100_err", cfg_err, 1);
        tick();
        chk("to_settle_en", tg_enable, 1);
        chk("to_settle_blank", blank, 1);
        // asynchronous reset in SETTLE
        rst_n = 1'b0;
        #1;
        chk("arst_enable", tg_enable, 0);
        chk("arst_blank", blank, 1);
        chk("arst_busy", busy, 0);
        chk("arst_err", cfg_err, 0);
        chk("arst_h_active", tg_h_active, 3840);
        chk("arst_h_sync", tg_h_sync, 24);
        chk("arst_v_active", tg_v_active, 2160);
        tick();
        rst_n = 1'b1;
        tick();
        // commit with enable=0 from OFF loads fields and returns to OFF
        do_commit();
        chk("dis_load_pulse", tg_load, 0);
        chk("dis_enable", tg_enable, 0);
        chk("dis_busy", busy, 1);
        tick();
        chk("dis_off_busy", busy, 0);
        chk("dis_off_blank", blank, 1);
        rd(9);
        chk("dis_status", rdat, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
